// File: rtl/pwm_capture.sv
// PWM period / high-time capture: measures a clk-asynchronous PWM input in clk cycles
// and reports each completed period with a one-cycle valid, or a timeout when out of range.
module pwm_capture #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             pwm_in,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] high_time,
    output logic             valid,
    output logic             timeout
);

    typedef enum logic [1:0] {
        ARM  = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    // synchronizer chain and edge detect
    logic s1_q, s2_q, s3_q;
    logic rise, fall;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] per_cnt_q, per_cnt_d;
    logic [WIDTH-1:0] hi_cnt_q, hi_cnt_d;
    logic [WIDTH-1:0] hi_lat_q, hi_lat_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic [WIDTH-1:0] high_time_q, high_time_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;

    assign rise = s2_q & ~s3_q;
    assign fall = ~s2_q & s3_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= pwm_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        per_cnt_d   = per_cnt_q;
        hi_cnt_d    = hi_cnt_q;
        hi_lat_d    = hi_lat_q;
        period_d    = period_q;
        high_time_d = high_time_q;
        valid_d     = 1'b0;
        timeout_d   = 1'b0;

        if (!en) begin
            state_d   = ARM;
            per_cnt_d = '0;
            hi_cnt_d  = '0;
            hi_lat_d  = '0;
        end else begin
            unique case (state_q)
                ARM: begin
                    if (rise) begin
                        per_cnt_d = CNT_ONE;
                        hi_cnt_d  = CNT_ONE;
                        state_d   = HIGH;
                    end else begin
                        per_cnt_d = '0;
                        hi_cnt_d  = '0;
                    end
                end
                HIGH: begin
                    // a rise cannot occur while high, so the range check alone decides timeout
                    if (per_cnt_q == CNT_MAX) begin
                        timeout_d = 1'b1;
                        state_d   = ARM;
                        per_cnt_d = '0;
                        hi_cnt_d  = '0;
                        hi_lat_d  = '0;
                    end else if (fall) begin
                        hi_lat_d  = hi_cnt_q;
                        per_cnt_d = per_cnt_q + CNT_ONE;
                        state_d   = LOW;
                    end else begin
                        per_cnt_d = per_cnt_q + CNT_ONE;
                        hi_cnt_d  = hi_cnt_q + CNT_ONE;
                    end
                end
                LOW: begin
                    if (rise) begin
                        period_d    = per_cnt_q;
                        high_time_d = hi_lat_q;
                        valid_d     = 1'b1;
                        per_cnt_d   = CNT_ONE;
                        hi_cnt_d    = CNT_ONE;
                        state_d     = HIGH;
                    end else if (per_cnt_q == CNT_MAX) begin
                        timeout_d = 1'b1;
                        state_d   = ARM;
                        per_cnt_d = '0;
                        hi_cnt_d  = '0;
                        hi_lat_d  = '0;
                    end else begin
                        per_cnt_d = per_cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d   = ARM;
                    per_cnt_d = '0;
                    hi_cnt_d  = '0;
                    hi_lat_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ARM;
            per_cnt_q   <= '0;
            hi_cnt_q    <= '0;
            hi_lat_q    <= '0;
            period_q    <= '0;
            high_time_q <= '0;
            valid_q     <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            per_cnt_q   <= per_cnt_d;
            hi_cnt_q    <= hi_cnt_d;
            hi_lat_q    <= hi_lat_d;
            period_q    <= period_d;
            high_time_q <= high_time_d;
            valid_q     <= valid_d;
            timeout_q   <= timeout_d;
        end
    end

    assign period    = period_q;
    assign high_time = high_time_q;
    assign valid     = valid_q;
    assign timeout   = timeout_q;

endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 Parameter: WIDTH, 8, bit width of the period and high-time counters and outputs.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 en  input  1  capture enable; low forces re-arm.
REQ-005 pwm_in  input  1  PWM signal, asynchronous to clk.
REQ-006 period  output  WIDTH  last measured period in clk cycles, registered.
REQ-007 high_time  output  WIDTH  last measured high time in clk cycles, registered.
REQ-008 valid  output  1  one-cycle pulse when period/high_time update.
REQ-009 timeout  output  1  one-cycle pulse when a period exceeds the counter range.

Function
REQ-010 pwm_in SHALL pass through a 2-flop synchronizer (s1, s2), plus a third flop s3 for edge detection.
REQ-011 Rise SHALL be s2 & ~s3; fall SHALL be ~s2 & s3; both evaluated in the same cycle.
REQ-012 FSM states SHALL be ARM (wait for first rise), HIGH (input high), LOW (input low, within a period).
REQ-013 ARM: on rise, per_cnt <= 1, hi_cnt <= 1, go HIGH; otherwise hold counters at 0.
REQ-014 HIGH: each cycle without fall, per_cnt and hi_cnt SHALL increment by 1.
REQ-015 HIGH: on fall, hi_lat <= hi_cnt, per_cnt increments, go LOW.
REQ-016 LOW: each cycle without rise, per_cnt SHALL increment; hi_cnt holds.
REQ-017 LOW: on rise, period <= per_cnt, high_time <= hi_lat, valid <= 1 for one cycle, per_cnt <= 1, hi_cnt <= 1, go HIGH.
REQ-018 Measured period SHALL equal the clk-cycle count between consecutive detected rises; high_time SHALL equal the cycle count from rise to fall.
REQ-019 Latency: valid SHALL be high in the cycle after the 3rd clk edge sampling the new pwm_in rise.
REQ-020 Maximum measurable period SHALL be 2^WIDTH-1; counters SHALL never wrap.
REQ-021 In HIGH or LOW, if per_cnt == 2^WIDTH-1 and no rise this cycle: timeout <= 1 for one cycle, go ARM, counters cleared, period/high_time unchanged.
REQ-022 Constant high or constant low input (0%/100% duty) SHALL therefore produce timeout, never valid.
REQ-023 valid and timeout SHALL never assert in the same cycle.
REQ-024 en low SHALL force ARM and clear counters in the same edge; period/high_time hold; valid/timeout stay 0.
REQ-025 After en returns high, first valid SHALL require two detected rises.
REQ-026 Pulses narrower than one clk period may be missed; no requirement on them.
REQ-027 Synchronizer flops SHALL run regardless of en.

Reset
REQ-028 reset SHALL override en and all edges.
REQ-029 On reset: state ARM, per_cnt/hi_cnt/hi_lat 0, period 0, high_time 0, valid 0, timeout 0, s1/s2/s3 0.
REQ-030 reset mid-period SHALL discard the partial measurement; no valid or timeout follows.

Verification
REQ-031 Reset held 3 cycles, pwm_in toggling -> period=0, high_time=0, valid=0, timeout=0 throughout.
REQ-032 pwm_in period 10 clk, high 3 clk, en=1 -> after 2nd rise, valid pulses every 10 cycles with period=10, high_time=3.
REQ-033 Running at 10/3, then pwm_in held low -> one timeout pulse 255 cycles after last detected rise, period/high_time stay 10/3, no further valid.
REQ-034 Period 255 high 100 -> valid with period=255, high_time=100; period 256 -> timeout, no valid.
REQ-035 en dropped for 5 cycles mid-HIGH at 10/3 -> no valid for that period; first new valid on 2nd rise after en=1, values 10/3.
REQ-036 reset pulsed one cycle mid-LOW -> outputs 0 next cycle; next valid only after two further rises.
